// File: rtl/mem_cache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller with word-wide backing memory.
// Define MEM_CACHE_STATS_EN to build saturating hit/request statistics counters.
module mem_cache_ctrl #(
    parameter int IDX_BITS = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        rd,
    input  logic        wr,
    output logic [15:0] data_out,
    output logic        done,
    output logic        stall,
    output logic        err,
    output logic        cache_req,
    output logic        cache_hit,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic [15:0] hit_count,
    output logic [15:0] req_count
);

    localparam int LINES    = 1 << IDX_BITS;
    localparam int WORDS    = LINES * 4;
    localparam int TAG_BITS = 13 - IDX_BITS;

    // Low two bits of the WB/FILL encodings are the word number being transferred.
    typedef enum logic [3:0] {
        IDLE  = 4'b0000,
        RESP  = 4'b0001,
        WB0   = 4'b0100,
        WB1   = 4'b0101,
        WB2   = 4'b0110,
        WB3   = 4'b0111,
        FILL0 = 4'b1000,
        FILL1 = 4'b1001,
        FILL2 = 4'b1010,
        FILL3 = 4'b1011
    } stateT;

    stateT state, nextState;

    logic [LINES-1:0]    validQ, dirtyQ;
    logic [TAG_BITS-1:0] tagArr [LINES];
    logic [15:0]         dataArr [WORDS];

    logic [IDX_BITS-1:0] reqIdx, idxQ;
    logic [TAG_BITS-1:0] reqTag, tagQ, victimTagQ;
    logic [1:0]          reqOff, offQ, wordSel;
    logic                opWrQ;
    logic [15:0]         dataQ;
    logic                lookupHit;

    logic                doneC, stallC, errC, cacheReqC, cacheHitC, memRdC, memWrC;
    logic [15:0]         dataOutC, memAddrC, memWdataC;
    logic                arrWe, setDirty, fillDone, latchReq;
    logic [IDX_BITS+1:0] arrWAddr;
    logic [15:0]         arrWData;
    logic [IDX_BITS-1:0] dirtyIdx;

    assign reqOff    = addr[2:1];
    assign reqIdx    = addr[2+IDX_BITS:3];
    assign reqTag    = addr[15:3+IDX_BITS];
    assign wordSel   = state[1:0];
    assign lookupHit = validQ[reqIdx] && (tagArr[reqIdx] == reqTag);

    // Next-state and output decode; hits finish combinationally in IDLE.
    always_comb begin
        nextState = state;
        doneC     = 1'b0;
        stallC    = 1'b0;
        errC      = 1'b0;
        cacheReqC = 1'b0;
        cacheHitC = 1'b0;
        memRdC    = 1'b0;
        memWrC    = 1'b0;
        dataOutC  = '0;
        memAddrC  = '0;
        memWdataC = '0;
        arrWe     = 1'b0;
        arrWAddr  = '0;
        arrWData  = '0;
        setDirty  = 1'b0;
        dirtyIdx  = '0;
        fillDone  = 1'b0;
        latchReq  = 1'b0;
        case (state)
            IDLE: begin
                if (rd || wr) begin
                    if (addr[0]) begin
                        errC  = 1'b1;
                        doneC = 1'b1;
                    end else if (lookupHit) begin
                        doneC     = 1'b1;
                        cacheReqC = 1'b1;
                        cacheHitC = 1'b1;
                        if (wr) begin
                            arrWe    = 1'b1;
                            arrWAddr = {reqIdx, reqOff};
                            arrWData = data_in;
                            setDirty = 1'b1;
                            dirtyIdx = reqIdx;
                        end else begin
                            dataOutC = dataArr[{reqIdx, reqOff}];
                        end
                    end else begin
                        cacheReqC = 1'b1;
                        stallC    = 1'b1;
                        latchReq  = 1'b1;
                        nextState = (validQ[reqIdx] && dirtyQ[reqIdx]) ? WB0 : FILL0;
                    end
                end
            end
            WB0, WB1, WB2, WB3: begin
                stallC    = 1'b1;
                memWrC    = 1'b1;
                memAddrC  = {victimTagQ, idxQ, wordSel, 1'b0};
                memWdataC = dataArr[{idxQ, wordSel}];
                if (mem_ack) begin
                    nextState = (state == WB3) ? FILL0 : stateT'(state + 4'd1);
                end
            end
            FILL0, FILL1, FILL2, FILL3: begin
                stallC   = 1'b1;
                memRdC   = 1'b1;
                memAddrC = {tagQ, idxQ, wordSel, 1'b0};
                if (mem_ack) begin
                    arrWe    = 1'b1;
                    arrWAddr = {idxQ, wordSel};
                    arrWData = mem_rdata;
                    if (state == FILL3) begin
                        fillDone  = 1'b1;
                        nextState = RESP;
                    end else begin
                        nextState = stateT'(state + 4'd1);
                    end
                end
            end
            RESP: begin
                doneC     = 1'b1;
                nextState = IDLE;
                if (opWrQ) begin
                    arrWe    = 1'b1;
                    arrWAddr = {idxQ, offQ};
                    arrWData = dataQ;
                    setDirty = 1'b1;
                    dirtyIdx = idxQ;
                end else begin
                    dataOutC = dataArr[{idxQ, offQ}];
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Outputs are forced low while reset is held so an abort is visible immediately.
    assign done      = doneC & ~rst;
    assign stall     = stallC & ~rst;
    assign err       = errC & ~rst;
    assign cache_req = cacheReqC & ~rst;
    assign cache_hit = cacheHitC & ~rst;
    assign mem_rd    = memRdC & ~rst;
    assign mem_wr    = memWrC & ~rst;
    assign data_out  = rst ? 16'h0 : dataOutC;
    assign mem_addr  = rst ? 16'h0 : memAddrC;
    assign mem_wdata = rst ? 16'h0 : memWdataC;

    // State, line status bits and the miss context captured at detection time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            validQ     <= '0;
            dirtyQ     <= '0;
            idxQ       <= '0;
            tagQ       <= '0;
            victimTagQ <= '0;
            offQ       <= '0;
            opWrQ      <= 1'b0;
            dataQ      <= '0;
        end else begin
            state <= nextState;
            if (latchReq) begin
                idxQ       <= reqIdx;
                tagQ       <= reqTag;
                victimTagQ <= tagArr[reqIdx];
                offQ       <= reqOff;
                opWrQ      <= wr;
                dataQ      <= data_in;
            end
            if (fillDone) begin
                validQ[idxQ] <= 1'b1;
                dirtyQ[idxQ] <= 1'b0;
            end
            if (setDirty) begin
                dirtyQ[dirtyIdx] <= 1'b1;
            end
        end
    end

    // Tag and data storage carry no reset; the valid bits qualify them.
    always_ff @(posedge clk) begin
        if (arrWe && !rst) begin
            dataArr[arrWAddr] <= arrWData;
        end
        if (fillDone && !rst) begin
            tagArr[idxQ] <= tagQ;
        end
    end

`ifdef MEM_CACHE_STATS_EN
    logic [15:0] hitCnt, reqCnt;

    // Saturating counters so long runs never wrap back to small values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hitCnt <= '0;
            reqCnt <= '0;
        end else begin
            if (cacheReqC && (reqCnt != 16'hFFFF)) begin
                reqCnt <= reqCnt + 16'd1;
            end
            if (cacheHitC && (hitCnt != 16'hFFFF)) begin
                hitCnt <= hitCnt + 16'd1;
            end
        end
    end

    assign hit_count = hitCnt;
    assign req_count = reqCnt;
`else
    assign hit_count = '0;
    assign req_count = '0;
`endif

endmodule

// File: tb/tb_mem_cache_ctrl.sv
// Scoreboard bench for mem_cache_ctrl: directed accesses against a behavioural backing memory
// with two-cycle acknowledge latency.
module tb_mem_cache_ctrl;

    localparam int IDX_BITS = 5;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr, dataIn, dataOut, memAddr, memWdata, memRdata, hitCount, reqCount;
    logic        rd, wr, done, stall, err, cacheReq, cacheHit, memRd, memWr, memAck;

    mem_cache_ctrl #(.IDX_BITS(IDX_BITS)) dut (
        .clk(clk), .rst(rst), .addr(addr), .data_in(dataIn), .rd(rd), .wr(wr),
        .data_out(dataOut), .done(done), .stall(stall), .err(err),
        .cache_req(cacheReq), .cache_hit(cacheHit), .mem_addr(memAddr),
        .mem_rd(memRd), .mem_wr(memWr), .mem_wdata(memWdata), .mem_rdata(memRdata),
        .mem_ack(memAck), .hit_count(hitCount), .req_count(reqCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        isLoad;
        logic        err;
        logic        hit;
        logic [15:0] data;
        logic [15:0] addr;
    } expT;

    expT         sbQ[$];
    expT         mon;
    int          tests = 0;
    int          fails = 0;
    int          reqPulses = 0;
    int          hitPulses = 0;
    int          busyCycles = 0;
    int          memLat = 0;
    bit          scoreEn = 1'b1;
    logic [15:0] backMem [0:32767];
    logic [15:0] rdLog[$];
    logic [31:0] wrLog[$];

    function automatic logic [15:0] initWord(input logic [15:0] a);
        return a ^ 16'h5A5A;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Backing memory: acknowledges each request two cycles after it appears.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            memAck = 1'b0;
            memLat = 0;
        end else if (memAck) begin
            memAck = 1'b0;
            memLat = 0;
        end else if (memRd || memWr) begin
            checkOutput("rdWrExclusive", 16'(memRd & memWr), 16'h0);
            memLat++;
            if (memLat == 2) begin
                memAck = 1'b1;
                if (memRd) begin
                    memRdata = backMem[memAddr[15:1]];
                    rdLog.push_back(memAddr);
                end else begin
                    backMem[memAddr[15:1]] = memWdata;
                    wrLog.push_back({memAddr, memWdata});
                end
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT reports completion.
    always @(negedge clk) begin
        if (!rst) begin
            reqPulses  += int'(cacheReq);
            hitPulses  += int'(cacheHit);
            busyCycles += int'(memRd | memWr);
            if (done && scoreEn) begin
                if (sbQ.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpectedDone: got done at addr %h, expected none", addr);
                end else begin
                    mon = sbQ.pop_front();
                    checkOutput("err", 16'(err), 16'(mon.err));
                    checkOutput("cacheHit", 16'(cacheHit), 16'(mon.hit));
                    if (mon.isLoad) checkOutput("loadData", dataOut, mon.data);
                end
            end
        end
    end

    task automatic applyStimulus(input logic [15:0] a, input logic [15:0] d, input logic r,
                                 input logic w, input logic [15:0] expData, input logic expHit,
                                 input logic expErr);
        expT e;
        int  r0 = reqPulses;
        int  h0 = hitPulses;
        bit  seen = 1'b0;
        e.isLoad = r && !w;
        e.err    = expErr;
        e.hit    = expHit;
        e.data   = expData;
        e.addr   = a;
        sbQ.push_back(e);
        @(posedge clk);
        #1;
        addr = a; dataIn = d; rd = r; wr = w;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            checkOutput("stallDuringMiss", 16'(stall), 16'h1);
        end
        if (!seen) begin
            tests++;
            fails++;
            $display("[TB] FAIL timeout: got no done for addr %h, expected done within 200 cycles", a);
        end else begin
            checkOutput("stallAtDone", 16'(stall), 16'h0);
        end
        @(posedge clk);
        #1;
        rd = 1'b0; wr = 1'b0;
        checkOutput("reqPulses", 16'(reqPulses - r0), expErr ? 16'h0 : 16'h1);
        checkOutput("hitPulses", 16'(hitPulses - h0), 16'(expHit));
    endtask

    initial begin
        int          busy0;
        logic [15:0] req0;
        bit          found;
        for (int i = 0; i < 32768; i++) backMem[i] = initWord(16'(i * 2));
        rst = 1'b1; addr = '0; dataIn = '0; rd = 1'b0; wr = 1'b0;
        memAck = 1'b0; memRdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("resetDone", 16'(done), 16'h0);
        checkOutput("resetStall", 16'(stall), 16'h0);
        checkOutput("resetMemRd", 16'(memRd), 16'h0);
        checkOutput("resetMemWr", 16'(memWr), 16'h0);
        checkOutput("resetCacheReq", 16'(cacheReq), 16'h0);
        checkOutput("resetHitCount", hitCount, 16'h0);
        checkOutput("resetReqCount", reqCount, 16'h0);

        // Cold miss: four fill reads of the whole line.
        rdLog.delete();
        applyStimulus(16'h0010, 16'h0, 1'b1, 1'b0, 16'h5A4A, 1'b0, 1'b0);
        checkOutput("fillCount", 16'(rdLog.size()), 16'd4);
        if (rdLog.size() >= 4)
            for (int i = 0; i < 4; i++) checkOutput("fillAddr", rdLog[i], 16'(16'h0010 + 2 * i));

        // Hit in the same line: no backing traffic.
        busy0 = busyCycles;
        applyStimulus(16'h0012, 16'h0, 1'b1, 1'b0, 16'h5A48, 1'b1, 1'b0);
        checkOutput("hitNoTraffic", 16'(busyCycles - busy0), 16'h0);

        // Store hit makes the line dirty; a conflicting load must write it back first.
        applyStimulus(16'h0010, 16'hBEEF, 1'b0, 1'b1, 16'h0, 1'b1, 1'b0);
        rdLog.delete(); wrLog.delete();
        applyStimulus(16'h0110, 16'h0, 1'b1, 1'b0, 16'h5B4A, 1'b0, 1'b0);
        checkOutput("wbCount", 16'(wrLog.size()), 16'd4);
        if (wrLog.size() >= 2) begin
            checkOutput("wbAddr0", wrLog[0][31:16], 16'h0010);
            checkOutput("wbData0", wrLog[0][15:0], 16'hBEEF);
            checkOutput("wbData1", wrLog[1][15:0], 16'h5A48);
        end
        checkOutput("backMem0010", backMem[16'h0008], 16'hBEEF);
        if (rdLog.size() >= 1) checkOutput("fillAfterWb", rdLog[0], 16'h0110);

        // Clean victim: refetch of the written-back word with no write-back.
        wrLog.delete();
        applyStimulus(16'h0010, 16'h0, 1'b1, 1'b0, 16'hBEEF, 1'b0, 1'b0);
        checkOutput("cleanNoWb", 16'(wrLog.size()), 16'h0);

        // rd and wr together is a store (allocating miss), then read it back.
        applyStimulus(16'h0020, 16'h1234, 1'b1, 1'b1, 16'h0, 1'b0, 1'b0);
        applyStimulus(16'h0020, 16'h0, 1'b1, 1'b0, 16'h1234, 1'b1, 1'b0);

        // Unaligned access.
        busy0 = busyCycles;
        req0  = reqCount;
        applyStimulus(16'h0011, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0, 1'b1);
        checkOutput("errNoTraffic", 16'(busyCycles - busy0), 16'h0);
        checkOutput("errReqCount", reqCount, req0);

        // Reset in FILL2 aborts; the same address misses afterwards.
        @(posedge clk);
        #1 addr = 16'h0040; rd = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (memRd && memAddr == 16'h0044) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            tests++;
            fails++;
            $display("[TB] FAIL reachFill2: got no read of 0044, expected one within 100 cycles");
        end
        #1 rst = 1'b1;
        #1;
        checkOutput("abortMemRd", 16'(memRd), 16'h0);
        checkOutput("abortStall", 16'(stall), 16'h0);
        checkOutput("abortMemAddr", memAddr, 16'h0);
        rd = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("abortHitCount", hitCount, 16'h0);
        rdLog.delete();
        applyStimulus(16'h0040, 16'h0, 1'b1, 1'b0, 16'h5A1A, 1'b0, 1'b0);
        checkOutput("refillCount", 16'(rdLog.size()), 16'd4);

`ifdef MEM_CACHE_STATS_EN
        checkOutput("reqCountAfterMiss", reqCount, 16'd1);
        scoreEn = 1'b0;
        @(posedge clk);
        #1 addr = 16'h0040; rd = 1'b1;
        repeat (65540) @(posedge clk);
        #1 rd = 1'b0;
        scoreEn = 1'b1;
        checkOutput("hitCountSat", hitCount, 16'hFFFF);
        checkOutput("reqCountSat", reqCount, 16'hFFFF);
`else
        checkOutput("hitCountTied", hitCount, 16'h0);
        checkOutput("reqCountTied", reqCount, 16'h0);
`endif

        repeat (2) @(posedge clk);
        checkOutput("scoreboardEmpty", 16'(sbQ.size()), 16'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
